rle_key_looper: RTL and testbench
=================================

Name: rle_key_looper

Overview:
- Synthesisable, multi-channel successor to the file-based key recorder/player.
- Run-length encodes a held key code stream (ascii note codes) into on-chip memory, one independent track per channel (buzzer A, B, ...).
- Plays a selected track back cycle-exactly, with optional looping.
- Sits between the keyboard decoder (key_in) and the buzzer tone generators (key_out).

Parameters:
- KEY_W, 7, width of key/note code; code 0 = silence.
- CNT_W, 16, run-length counter width; max run per entry = 2^CNT_W-1 cycles.
- DEPTH, 256, entries per channel track.
- NCH, 2, number of independent tracks.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- key_in  in  KEY_W  live key code, sampled every clk.
- ch_sel  in  max(1,$clog2(NCH))  track selected for the next record/play; latched at session start.
- rec_en  in  1  level; record while high.
- play_en  in  1  level; play while high.
- loop_en  in  1  level; on end of track restart at entry 0, else stop.
- key_out  out  KEY_W  played key code; 0 when not playing.
- key_valid  out  1  key_out carries track data.
- busy  out  1  state != IDLE.
- full  out  1  pulse (1 cycle) when a recording is truncated at DEPTH entries.
- track_len  out  $clog2(DEPTH+1)  entry count of the currently selected track (combinational read of the length register).

Behaviour:
- Reset: all outputs 0, state IDLE, every track length 0. Memory contents are not reset; length 0 marks a track empty.
- FSM: IDLE, REC, FLUSH, PLAY_PRIME, PLAY.
- IDLE:
  - rec_en=1: latch ch, cur_key<=key_in, cnt<=1, wptr<=0, go REC. Record wins if rec_en and play_en are both high.
  - Else play_en=1 and track_len!=0: latch ch, issue read of entry 0, go PLAY_PRIME.
  - play_en on an empty track: stay IDLE, key_valid=0.
- REC, each cycle:
  - key_in==cur_key and cnt<max: cnt++.
  - key_in==cur_key and cnt==max: write {cur_key,max}, cnt<=1. Long runs split into multiple entries; never dropped.
  - key_in!=cur_key: write {cur_key,cnt}, cur_key<=key_in, cnt<=1.
  - Each write does wptr++.
  - rec_en low: go FLUSH.
- FLUSH: write the final {cur_key,cnt}, len[ch]<=wptr+1, go IDLE.
- Full handling: if a write would be entry DEPTH, drop it. Set len[ch]=DEPTH, pulse full, go IDLE (from REC or FLUSH).
- Entry stored count is always >=1.
- PLAY_PRIME: capture entry 0 (1-cycle sync-read latency), issue read of entry 1 (or 0 if len==1), go PLAY.
  - key_valid rises 2 cycles after the play_en edge in IDLE.
- PLAY:
  - key_out=entry key, held exactly count cycles.
  - On the last cycle of an entry, the prefetched next entry is loaded and the following read is issued. No bubbles between entries.
  - After the last entry: loop_en=1 wraps to entry 0 seamlessly; loop_en=0 goes IDLE with key_out=0, key_valid=0 next cycle.
  - play_en low: go IDLE next cycle, outputs 0.
- Recording overwrites only the latched channel; the other tracks are untouched.
- ch_sel changes mid-session are ignored.
- rst_n asserted mid-session: immediate IDLE, all lengths 0, no partial track retained.
- Counter arithmetic is unsigned CNT_W; wptr/rptr are $clog2(DEPTH) wide with an explicit DEPTH compare (no silent wrap).

Decomposition:
- Package rle_pkg:
  - entry_t struct {key[KEY_W], cnt[CNT_W]}.
  - state_e enum.
  - CNT_MAX constant.
- Sub-module rle_track_mem: simple dual-port RAM, NCH*DEPTH x (KEY_W+CNT_W), 1 write port, 1 sync read port, address = {ch,ptr}. Infers block RAM.

Test Plan:
- Record ch0: key 60 for 3 cycles, 62 for 1, 0 for 5, then rec_en low -> len[0]=3, entries {60,3},{62,1},{0,5}. Play loop_en=0 -> key_out 60x3,62x1,0x5 starting 2 cycles after play_en, key_valid then drops.
- Same track with loop_en=1 for 20 cycles -> sequence repeats with period 9, no gap at wrap.
- CNT_W=4, key 65 held 20 cycles -> entries {65,15},{65,5}; playback gives 65 for 20 consecutive cycles.
- DEPTH=4, record 6 alternating keys -> full pulses once, len=4, playback emits only the first 4 runs.
- Record ch1 while ch0 holds data, then play ch0 -> ch0 output unchanged. play_en on an empty ch with NCH=4 -> key_valid stays 0.
- rec_en and play_en rise together -> recording occurs. rst_n pulse mid-PLAY -> outputs 0 immediately, track_len=0 afterwards.

Source files
------------

// File: rtl/rle_pkg.sv
// Shared types and defaults for the run-length key looper.
package rle_pkg;

  localparam int KEY_W_DEF = 7;
  localparam int CNT_W_DEF = 16;
  localparam int DEPTH_DEF = 256;
  localparam int NCH_DEF   = 2;

  localparam logic [CNT_W_DEF-1:0] CNT_MAX = {CNT_W_DEF{1'b1}};

  typedef struct packed {
    logic [KEY_W_DEF-1:0] key;
    logic [CNT_W_DEF-1:0] cnt;
  } entry_t;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    REC        = 3'd1,
    FLUSH      = 3'd2,
    PLAY_PRIME = 3'd3,
    PLAY       = 3'd4
  } state_e;

endpackage

// File: rtl/rle_track_mem.sv
// Track storage: one write port, one synchronous read port, address {channel, pointer}.
module rle_track_mem #(
  parameter int AW    = 9,
  parameter int DW    = 23,
  parameter int WORDS = 512
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem_r [WORDS];

  // Write port
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Synchronous read port, one cycle latency
  always_ff @(posedge clk) begin
    rd_data <= mem_r[rd_addr];
  end

endmodule

// File: rtl/rle_key_looper.sv
// Run-length key recorder/player: records key_in runs into per-channel tracks
// and replays a selected track cycle-exactly, optionally looping.
module rle_key_looper
  import rle_pkg::*;
#(
  parameter int KEY_W = KEY_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int NCH   = NCH_DEF,
  localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int LW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [KEY_W-1:0] key_in,
  input  logic [CHW-1:0]   ch_sel,
  input  logic             rec_en,
  input  logic             play_en,
  input  logic             loop_en,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid,
  output logic             busy,
  output logic             full,
  output logic [LW-1:0]    track_len
);

  localparam int PW = $clog2(DEPTH);
  localparam int DW = KEY_W + CNT_W;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_TOP  = {CNT_W{1'b1}};
  localparam logic [PW-1:0]    PTR_ZERO = {PW{1'b0}};
  localparam logic [PW-1:0]    PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0]    PTR_LAST = PW'(DEPTH - 1);
  localparam logic [LW-1:0]    LEN_ZERO = {LW{1'b0}};
  localparam logic [LW-1:0]    LEN_ONE  = {{(LW-1){1'b0}}, 1'b1};
  localparam logic [LW-1:0]    LEN_FULL = LW'(DEPTH);

  state_e           state_r;
  logic [CHW-1:0]   ch_r;
  logic [KEY_W-1:0] cur_key_r, key_out_r;
  logic [CNT_W-1:0] cnt_r, rem_r;
  logic [PW-1:0]    wptr_r, rptr_r, pf_ptr_r;
  logic             wdone_r, key_valid_r, busy_r, full_r;
  logic [LW-1:0]    len_r [NCH];

  logic [LW-1:0]    sel_len_s, cur_len_s;
  logic [PW-1:0]    last_idx_s, pf_next_s, rd_ptr_s;
  logic [CHW-1:0]   rd_ch_s;
  logic [DW-1:0]    rd_data_s;
  logic [KEY_W-1:0] rd_key_s;
  logic [CNT_W-1:0] rd_cnt_s;
  logic             rec_step_s, wr_en_s;

  assign sel_len_s  = len_r[ch_sel];
  assign cur_len_s  = len_r[ch_r];
  assign last_idx_s = PW'(cur_len_s - LEN_ONE);
  assign pf_next_s  = (pf_ptr_r == last_idx_s) ? PTR_ZERO : pf_ptr_r + PTR_ONE;
  assign rd_key_s   = rd_data_s[DW-1:CNT_W];
  assign rd_cnt_s   = rd_data_s[CNT_W-1:0];

  // A run closes on a key change or when its counter saturates; wdone_r means every slot is used
  assign rec_step_s = rec_en && ((key_in != cur_key_r) || (cnt_r == CNT_TOP));
  assign wr_en_s    = !wdone_r && (((state_r == REC) && rec_step_s) || (state_r == FLUSH));

  // Read address is issued combinationally so the entry lands exactly when it is needed
  always_comb begin
    rd_ch_s  = ch_r;
    rd_ptr_s = pf_ptr_r;
    case (state_r)
      IDLE: begin
        rd_ch_s  = ch_sel;
        rd_ptr_s = PTR_ZERO;
      end
      PLAY_PRIME: begin
        if (cur_len_s == LEN_ONE) rd_ptr_s = PTR_ZERO;
        else                      rd_ptr_s = PTR_ONE;
      end
      PLAY: begin
        if (rem_r == CNT_ONE) rd_ptr_s = pf_next_s;
        else                  rd_ptr_s = pf_ptr_r;
      end
      default: begin
        rd_ch_s  = ch_r;
        rd_ptr_s = pf_ptr_r;
      end
    endcase
  end

  rle_track_mem #(
    .AW   (CHW + PW),
    .DW   (DW),
    .WORDS(NCH * DEPTH)
  ) u_mem (
    .clk    (clk),
    .wr_en  (wr_en_s),
    .wr_addr({ch_r, wptr_r}),
    .wr_data({cur_key_r, cnt_r}),
    .rd_addr({rd_ch_s, rd_ptr_s}),
    .rd_data(rd_data_s)
  );

  // Record/playback state machine with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      ch_r        <= {CHW{1'b0}};
      cur_key_r   <= {KEY_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      rem_r       <= {CNT_W{1'b0}};
      wptr_r      <= PTR_ZERO;
      rptr_r      <= PTR_ZERO;
      pf_ptr_r    <= PTR_ZERO;
      wdone_r     <= 1'b0;
      key_out_r   <= {KEY_W{1'b0}};
      key_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      full_r      <= 1'b0;
      for (int i = 0; i < NCH; i++) len_r[i] <= LEN_ZERO;
    end else begin
      full_r   <= 1'b0;
      pf_ptr_r <= rd_ptr_s;
      case (state_r)
        IDLE: begin
          key_out_r   <= {KEY_W{1'b0}};
          key_valid_r <= 1'b0;
          if (rec_en) begin
            ch_r      <= ch_sel;
            cur_key_r <= key_in;
            cnt_r     <= CNT_ONE;
            wptr_r    <= PTR_ZERO;
            wdone_r   <= 1'b0;
            state_r   <= REC;
            busy_r    <= 1'b1;
          end else if (play_en && (sel_len_s != LEN_ZERO)) begin
            ch_r    <= ch_sel;
            state_r <= PLAY_PRIME;
            busy_r  <= 1'b1;
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        REC: begin
          if (!rec_en) begin
            state_r <= FLUSH;
          end else if (!rec_step_s) begin
            cnt_r <= cnt_r + CNT_ONE;
          end else if (wdone_r) begin
            len_r[ch_r] <= LEN_FULL;
            full_r      <= 1'b1;
            state_r     <= IDLE;
            busy_r      <= 1'b0;
          end else begin
            cur_key_r <= key_in;
            cnt_r     <= CNT_ONE;
            if (wptr_r == PTR_LAST) wdone_r <= 1'b1;
            else                    wptr_r  <= wptr_r + PTR_ONE;
          end
        end
        FLUSH: begin
          if (wdone_r) begin
            len_r[ch_r] <= LEN_FULL;
            full_r      <= 1'b1;
          end else begin
            len_r[ch_r] <= {{(LW-PW){1'b0}}, wptr_r} + LEN_ONE;
          end
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
        PLAY_PRIME: begin
          if (!play_en) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else begin
            key_out_r   <= rd_key_s;
            key_valid_r <= 1'b1;
            rem_r       <= rd_cnt_s;
            rptr_r      <= PTR_ZERO;
            state_r     <= PLAY;
          end
        end
        PLAY: begin
          if (!play_en || ((rem_r == CNT_ONE) && (rptr_r == last_idx_s) && !loop_en)) begin
            key_out_r   <= {KEY_W{1'b0}};
            key_valid_r <= 1'b0;
            state_r     <= IDLE;
            busy_r      <= 1'b0;
          end else if (rem_r != CNT_ONE) begin
            rem_r <= rem_r - CNT_ONE;
          end else begin
            key_out_r <= rd_key_s;
            rem_r     <= rd_cnt_s;
            rptr_r    <= (rptr_r == last_idx_s) ? PTR_ZERO : rptr_r + PTR_ONE;
          end
        end
        default: begin
          key_out_r   <= {KEY_W{1'b0}};
          key_valid_r <= 1'b0;
          state_r     <= IDLE;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign key_out   = key_out_r;
  assign key_valid = key_valid_r;
  assign busy      = busy_r;
  assign full      = full_r;
  assign track_len = sel_len_s;

endmodule

// File: tb/tb_rle_key_looper.sv
// Directed bench for rle_key_looper: a default instance driven from a per-cycle
// vector table, plus a small instance (CNT_W=4, DEPTH=4, NCH=4) for the corner cases.
module tb_rle_key_looper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n_s;
  logic [6:0] key_in_s, key_out_s;
  logic [0:0] ch_sel_s;
  logic       rec_en_s, play_en_s, loop_en_s, key_valid_s, busy_s, full_s;
  logic [8:0] track_len_s;

  logic [6:0] sm_key_in_s, sm_key_out_s;
  logic [1:0] sm_ch_sel_s;
  logic       sm_rec_en_s, sm_play_en_s, sm_loop_en_s, sm_key_valid_s, sm_busy_s, sm_full_s;
  logic [2:0] sm_track_len_s;

  int n_checks = 0;
  int n_pass   = 0;

  rle_key_looper dut (
    .clk(clk), .rst_n(rst_n_s), .key_in(key_in_s), .ch_sel(ch_sel_s),
    .rec_en(rec_en_s), .play_en(play_en_s), .loop_en(loop_en_s),
    .key_out(key_out_s), .key_valid(key_valid_s), .busy(busy_s),
    .full(full_s), .track_len(track_len_s)
  );

  rle_key_looper #(.KEY_W(7), .CNT_W(4), .DEPTH(4), .NCH(4)) dut_sm (
    .clk(clk), .rst_n(rst_n_s), .key_in(sm_key_in_s), .ch_sel(sm_ch_sel_s),
    .rec_en(sm_rec_en_s), .play_en(sm_play_en_s), .loop_en(sm_loop_en_s),
    .key_out(sm_key_out_s), .key_valid(sm_key_valid_s), .busy(sm_busy_s),
    .full(sm_full_s), .track_len(sm_track_len_s)
  );

  typedef struct {
    logic       rec, play, lp, ch;
    logic [6:0] key, ko;
    logic       kv, bsy, fl;
    logic [8:0] len;
  } vec_t;

  vec_t vecs[$];
  int   pat[9] = '{60, 60, 60, 62, 0, 0, 0, 0, 0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Row: inputs {rec, play, loop, ch, key}, expected after the edge {key_out, key_valid, busy, full, track_len}
  task automatic add(input int r, input int p, input int l, input int c, input int k,
                     input int ko, input int kv, input int b, input int f, input int ln);
    vec_t v;
    v.rec = r[0]; v.play = p[0]; v.lp = l[0]; v.ch = c[0]; v.key = k[6:0];
    v.ko = ko[6:0]; v.kv = kv[0]; v.bsy = b[0]; v.fl = f[0]; v.len = ln[8:0];
    vecs.push_back(v);
  endtask

  task automatic add_play_ch0_once();
    add(0, 1, 0, 0, 0, 0, 0, 1, 0, 3);
    for (int j = 0; j < 9; j++) add(0, 1, 0, 0, 0, pat[j], 1, 1, 0, 3);
    add(0, 1, 0, 0, 0, 0, 0, 0, 0, 3);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 3);
  endtask

  initial begin
    int full_cnt;
    rst_n_s = 1'b0;
    key_in_s = 7'd0; ch_sel_s = 1'b0; rec_en_s = 1'b0; play_en_s = 1'b0; loop_en_s = 1'b0;
    sm_key_in_s = 7'd0; sm_ch_sel_s = 2'd0; sm_rec_en_s = 1'b0; sm_play_en_s = 1'b0; sm_loop_en_s = 1'b0;
    repeat (2) tick();
    chk("reset_big", 32'({key_out_s, key_valid_s, busy_s, full_s, track_len_s}), 32'd0);
    chk("reset_small", 32'({sm_key_out_s, sm_key_valid_s, sm_busy_s, sm_full_s, sm_track_len_s}), 32'd0);
    @(negedge clk) rst_n_s = 1'b1;
    tick();
    chk("post_reset_big", 32'({key_out_s, key_valid_s, busy_s, full_s, track_len_s}), 32'd0);

    // Record ch0: 60x3, 62x1, 0x5
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int j = 0; j < 9; j++) add(1, 0, 0, 0, pat[j], 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 3);
    add_play_ch0_once();
    // Looping playback for 20 cycles, period 9, then play_en low
    add(0, 1, 1, 0, 0, 0, 0, 1, 0, 3);
    for (int j = 0; j < 20; j++) add(0, 1, 1, 0, 0, pat[j % 9], 1, 1, 0, 3);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, 3);
    // Record ch1 with play_en raised together (record wins); ch_sel moves to 0 mid-record
    add(1, 1, 0, 1, 70, 0, 0, 1, 0, 0);
    add(1, 0, 0, 1, 70, 0, 0, 1, 0, 0);
    add(1, 0, 0, 0, 71, 0, 0, 1, 0, 3);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0, 3);
    add(0, 0, 0, 1, 0, 0, 0, 0, 0, 2);
    // Play ch1 with ch_sel switched away after start
    add(0, 1, 0, 1, 0, 0, 0, 1, 0, 2);
    add(0, 1, 0, 0, 0, 70, 1, 1, 0, 3);
    add(0, 1, 0, 0, 0, 70, 1, 1, 0, 3);
    add(0, 1, 0, 0, 0, 71, 1, 1, 0, 3);
    add(0, 1, 0, 0, 0, 0, 0, 0, 0, 3);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 3);
    // ch0 untouched by the ch1 recording
    add_play_ch0_once();
    // play_en dropped mid-entry
    add(0, 1, 0, 0, 0, 0, 0, 1, 0, 3);
    add(0, 1, 0, 0, 0, 60, 1, 1, 0, 3);
    add(0, 1, 0, 0, 0, 60, 1, 1, 0, 3);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 3);

    foreach (vecs[i]) begin
      rec_en_s = vecs[i].rec; play_en_s = vecs[i].play; loop_en_s = vecs[i].lp;
      ch_sel_s = vecs[i].ch;  key_in_s  = vecs[i].key;
      tick();
      chk($sformatf("vec%0d", i), 32'({key_out_s, key_valid_s, busy_s, full_s, track_len_s}),
          32'({vecs[i].ko, vecs[i].kv, vecs[i].bsy, vecs[i].fl, vecs[i].len}));
    end

    // Small instance: key 65 held 20 cycles on ch2 splits into {65,15},{65,5}
    sm_ch_sel_s = 2'd2; sm_key_in_s = 7'd65; sm_rec_en_s = 1'b1;
    repeat (20) tick();
    sm_rec_en_s = 1'b0;
    tick();
    tick();
    chk("cnt_split_len", 32'({sm_busy_s, sm_full_s, sm_track_len_s}), 32'd2);
    sm_play_en_s = 1'b1;
    tick();
    chk("cnt_prime", 32'(sm_key_valid_s), 32'd0);
    for (int j = 0; j < 20; j++) begin
      tick();
      chk($sformatf("cnt_play%0d", j), 32'({sm_key_out_s, sm_key_valid_s}), 32'({7'd65, 1'b1}));
    end
    tick();
    chk("cnt_end", 32'({sm_key_valid_s, sm_busy_s}), 32'd0);
    sm_play_en_s = 1'b0;
    tick();

    // Small instance: 6 one-cycle keys on ch3 overflow a 4-entry track
    full_cnt = 0;
    sm_ch_sel_s = 2'd3;
    for (int k = 1; k <= 6; k++) begin
      sm_rec_en_s = 1'b1;
      sm_key_in_s = 7'(k);
      tick();
      if (sm_full_s) full_cnt++;
      chk($sformatf("full_k%0d", k), 32'({sm_full_s, sm_busy_s}), (k == 6) ? 32'd2 : 32'd1);
    end
    sm_rec_en_s = 1'b0;
    repeat (3) begin
      tick();
      if (sm_full_s) full_cnt++;
    end
    chk("full_once", 32'(full_cnt), 32'd1);
    chk("full_len", 32'(sm_track_len_s), 32'd4);
    sm_play_en_s = 1'b1;
    tick();
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("full_play%0d", k), 32'({sm_key_out_s, sm_key_valid_s}), 32'({7'(k), 1'b1}));
    end
    tick();
    chk("full_play_end", 32'({sm_key_valid_s, sm_busy_s}), 32'd0);
    sm_play_en_s = 1'b0;
    tick();

    // Small instance: play on empty tracks stays idle
    for (int c = 0; c < 2; c++) begin
      sm_ch_sel_s = 2'(c);
      sm_play_en_s = 1'b1;
      repeat (3) begin
        tick();
        chk($sformatf("empty_ch%0d", c), 32'({sm_key_valid_s, sm_busy_s, sm_track_len_s}), 32'd0);
      end
      sm_play_en_s = 1'b0;
      tick();
    end

    // Async reset in the middle of playback
    ch_sel_s = 1'b0; loop_en_s = 1'b1; play_en_s = 1'b1;
    repeat (3) tick();
    chk("pre_rst_play", 32'({key_out_s, key_valid_s}), 32'({7'd60, 1'b1}));
    #2 rst_n_s = 1'b0;
    #1;
    chk("rst_mid_out", 32'({key_out_s, key_valid_s, busy_s, full_s}), 32'd0);
    chk("rst_len_ch0", 32'(track_len_s), 32'd0);
    ch_sel_s = 1'b1;
    #1;
    chk("rst_len_ch1", 32'(track_len_s), 32'd0);
    @(negedge clk) rst_n_s = 1'b1;
    ch_sel_s = 1'b0;
    tick();
    tick();
    chk("rst_then_play", 32'({key_valid_s, busy_s, track_len_s}), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
